// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port byte-enable data RAM: read-during-write
// mode codes, byte-lane helper and the clear-sweep FSM states.
package ram_pkg;

    localparam int RDW_OLD = 0;   // read-first: reads return the word before the write
    localparam int RDW_NEW = 1;   // write-first: reads return the merged word

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    typedef enum logic {
        INIT,
        RUN
    } ram_state_t;

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take din, the rest keep old_word.
module ram_byte_merge
    import ram_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic [ANCHO-1:0]             old_word,
    input  logic [ANCHO-1:0]             din,
    input  logic [byte_lanes(ANCHO)-1:0] be,
    output logic [ANCHO-1:0]             new_word
);

    always_comb begin
        // NOTE: default assignment first so lanes left untouched by the loop cannot infer a latch.
        new_word = old_word;
        for (int i = 0; i < byte_lanes(ANCHO); i++) begin
            if (be[i]) new_word[8*i +: 8] = din[8*i +: 8];
        end
    end

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only,
// selectable read-during-write, optional output register and post-reset clear sweep.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int ANCHO    = 32,
    parameter int LARGO    = 1024,
    parameter int RDW_MODE = RDW_OLD,
    parameter int OUT_REG  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         init_busy,
    input  logic                         a_en,
    input  logic                         a_we,
    input  logic [byte_lanes(ANCHO)-1:0] a_be,
    input  logic [$clog2(LARGO)-1:0]     a_addr,
    input  logic [ANCHO-1:0]             a_din,
    output logic [ANCHO-1:0]             a_dout,
    output logic                         a_rvalid,
    input  logic                         b_en,
    input  logic [$clog2(LARGO)-1:0]     b_addr,
    output logic [ANCHO-1:0]             b_dout,
    output logic                         b_rvalid,
    output logic                         collision
);

    localparam int  AW       = $clog2(LARGO);
    localparam int  NB       = byte_lanes(ANCHO);
    localparam bit  WR_FIRST = (RDW_MODE == RDW_NEW);

    ram_state_t      state, state_nxt;
    logic [AW-1:0]   cnt;
    logic [ANCHO-1:0] mem [0:LARGO-1];

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) cnt <= cnt + AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (cnt == AW'(LARGO - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign init_busy = (state == INIT);

    logic             a_req, a_wr, b_req, hit;
    logic [ANCHO-1:0] a_old, b_old, a_merged, a_rd, b_rd;

    assign a_req = (state == RUN) && a_en;
    assign a_wr  = a_req && a_we;
    assign b_req = (state == RUN) && b_en;
    assign hit   = a_wr && b_req && (a_addr == b_addr);

    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];

    ram_byte_merge #(.ANCHO(ANCHO)) u_merge (
        .old_word (a_old),
        .din      (a_din),
        .be       (a_be),
        .new_word (a_merged)
    );

    assign a_rd = (WR_FIRST && a_wr) ? a_merged : a_old;
    assign b_rd = (WR_FIRST && hit)  ? a_merged : b_old;

    // NOTE: the array itself is never reset; the INIT sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // First read stage: data registers hold their value when the port is idle.
    logic             a_v1, b_v1, col1;
    logic [ANCHO-1:0] a_d1, b_d1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            col1 <= 1'b0;
            a_d1 <= '0;
            b_d1 <= '0;
        end else begin
            a_v1 <= a_req;
            b_v1 <= b_req;
            col1 <= hit;
            if (a_req) a_d1 <= a_rd;
            if (b_req) b_d1 <= b_rd;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             a_v2, b_v2, col2;
        logic [ANCHO-1:0] a_d2, b_d2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_v2 <= 1'b0;
                b_v2 <= 1'b0;
                col2 <= 1'b0;
                a_d2 <= '0;
                b_d2 <= '0;
            end else begin
                a_v2 <= a_v1;
                b_v2 <= b_v1;
                col2 <= col1;
                if (a_v1) a_d2 <= a_d1;
                if (b_v1) b_d2 <= b_d1;
            end
        end

        assign a_dout    = a_d2;
        assign a_rvalid  = a_v2;
        assign b_dout    = b_d2;
        assign b_rvalid  = b_v2;
        assign collision = col2;
    end else begin : g_no_out_reg
        assign a_dout    = a_d1;
        assign a_rvalid  = a_v1;
        assign b_dout    = b_d1;
        assign b_rvalid  = b_v1;
        assign collision = col1;
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench for ram_dp_be: four instances covering both read-during-write
// modes with and without the output register, checked against a word-level model.
module tb_ram_dp_be;
    import ram_pkg::*;

    localparam int ANCHO = 32;
    localparam int LARGO = 1024;
    localparam int AW    = 10;
    localparam int NDUT  = 4;   // instance c: RDW_MODE = c % 2, OUT_REG = c / 2

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             a_en, a_we, b_en;
    logic [3:0]       a_be;
    logic [AW-1:0]    a_addr, b_addr;
    logic [31:0]      a_din;

    logic             init_busy [NDUT];
    logic [31:0]      a_dout    [NDUT];
    logic [31:0]      b_dout    [NDUT];
    logic             a_rvalid  [NDUT];
    logic             b_rvalid  [NDUT];
    logic             collision [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_dp_be #(
            .ANCHO    (ANCHO),
            .LARGO    (LARGO),
            .RDW_MODE (g % 2),
            .OUT_REG  (g / 2)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .init_busy (init_busy[g]),
            .a_en      (a_en),
            .a_we      (a_we),
            .a_be      (a_be),
            .a_addr    (a_addr),
            .a_din     (a_din),
            .a_dout    (a_dout[g]),
            .a_rvalid  (a_rvalid[g]),
            .b_en      (b_en),
            .b_addr    (b_addr),
            .b_dout    (b_dout[g]),
            .b_rvalid  (b_rvalid[g]),
            .collision (collision[g])
        );
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          a_v;
        bit          b_v;
        bit          col;
        logic [31:0] a_old;
        logic [31:0] a_new;
        logic [31:0] b_old;
        logic [31:0] b_new;
    } res_t;

    logic [31:0] mem_m [LARGO];
    int          sweep_left;
    res_t        hist [$];          // hist[k] = request result issued k edges ago
    logic [31:0] last_a [NDUT];
    logic [31:0] last_b [NDUT];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge_m(input logic [31:0] old, input logic [31:0] din,
                                            input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old & ~mask) | (din & mask);
    endfunction

    task automatic compare();
        for (int c = 0; c < NDUT; c++) begin
            int          lat;
            res_t        e;
            logic [31:0] ea, eb;
            lat = 1 + c / 2;
            e   = '{default: 0};
            if (hist.size() >= lat) e = hist[lat - 1];
            ea = (c % 2 == 1) ? e.a_new : e.a_old;
            eb = (c % 2 == 1) ? e.b_new : e.b_old;
            if (e.a_v) last_a[c] = ea;
            if (e.b_v) last_b[c] = eb;
            check($sformatf("dut%0d init_busy", c), init_busy[c], (sweep_left > 0) ? 1 : 0);
            check($sformatf("dut%0d a_rvalid", c),  a_rvalid[c],  e.a_v);
            check($sformatf("dut%0d a_dout", c),    a_dout[c],    last_a[c]);
            check($sformatf("dut%0d b_rvalid", c),  b_rvalid[c],  e.b_v);
            check($sformatf("dut%0d b_dout", c),    b_dout[c],    last_b[c]);
            check($sformatf("dut%0d collision", c), collision[c], e.b_v && e.col);
        end
    endtask

    // Apply the current inputs across one rising edge and check every instance.
    task automatic cycle();
        res_t        r;
        logic [31:0] w;
        r = '{default: 0};
        if (!reset) begin
            if (sweep_left > 0) begin
                sweep_left--;
            end else begin
                r.a_v   = a_en;
                r.b_v   = b_en;
                r.a_old = mem_m[a_addr];
                r.b_old = mem_m[b_addr];
                r.a_new = r.a_old;
                r.b_new = r.b_old;
                if (a_en && a_we) begin
                    w       = merge_m(r.a_old, a_din, a_be);
                    r.a_new = w;
                    r.col   = b_en && (a_addr == b_addr);
                    if (r.col) r.b_new = w;
                    mem_m[a_addr] = w;
                end
            end
            hist.push_front(r);
            if (hist.size() > 2) void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic assert_reset();
        reset      = 1'b1;
        sweep_left = LARGO;
        hist.delete();
        for (int c = 0; c < NDUT; c++) begin
            last_a[c] = '0;
            last_b[c] = '0;
        end
        for (int i = 0; i < LARGO; i++) mem_m[i] = '0;
    endtask

    task automatic set_idle();
        a_en = 0; a_we = 0; a_be = 4'h0; a_addr = '0; a_din = '0;
        b_en = 0; b_addr = '0;
    endtask

    // Release reset and run the sweep with writes requested the whole time.
    task automatic sweep_with_traffic(input string name);
        int n;
        reset  = 1'b0;
        a_en = 1; a_we = 1; a_be = 4'hF; a_addr = 10'd13; a_din = 32'hDEADBEEF;
        b_en = 1; b_addr = 10'd13;
        n = 0;
        while (init_busy[0] && n < 3000) begin
            cycle();
            n++;
        end
        set_idle();
        check(name, n, LARGO);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          a_en;
        bit          a_we;
        logic [3:0]  be;
        logic [9:0]  aa;
        logic [31:0] din;
        bit          b_en;
        logic [9:0]  ba;
        logic [31:0] exp_a0;   // a_dout, read-first instance
        logic [31:0] exp_b0;   // b_dout, read-first instance
        logic [31:0] exp_b1;   // b_dout, write-first instance
        bit          exp_col;
    } vec_t;

    vec_t        tbl [9];
    bit          oreg_v [5] = '{0, 1, 1, 1, 0};
    logic [31:0] oreg_d [5] = '{32'h0, 32'h101, 32'h202, 32'h303, 32'h303};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_idle();
        #2;
        assert_reset();
        for (int i = 0; i < 3; i++) cycle();

        sweep_with_traffic("sweep length after power-up");

        tbl[0] = '{0, 0, 4'h0, 10'd0,    32'h0,        1, 10'd13, 32'h0,        32'h0,        32'h0,        0};
        tbl[1] = '{1, 0, 4'h0, 10'd0,    32'h0,        1, 10'd0,  32'h0,        32'h0,        32'h0,        0};
        tbl[2] = '{1, 0, 4'h0, 10'd1023, 32'h0,        0, 10'd0,  32'h0,        32'h0,        32'h0,        0};
        tbl[3] = '{1, 1, 4'hF, 10'd13,   32'h0000A234, 0, 10'd0,  32'h0,        32'h0,        32'h0,        0};
        tbl[4] = '{1, 0, 4'h0, 10'd13,   32'h0,        1, 10'd13, 32'h0000A234, 32'h0000A234, 32'h0000A234, 0};
        tbl[5] = '{1, 1, 4'hF, 10'd16,   32'h11223344, 0, 10'd0,  32'h0,        32'h0000A234, 32'h0000A234, 0};
        tbl[6] = '{1, 1, 4'h5, 10'd16,   32'hAABBCCDD, 1, 10'd16, 32'h11223344, 32'h11223344, 32'h11BB33DD, 1};
        tbl[7] = '{1, 1, 4'hF, 10'd16,   32'h00001234, 1, 10'd16, 32'h11BB33DD, 32'h11BB33DD, 32'h00001234, 1};
        tbl[8] = '{1, 0, 4'h0, 10'd16,   32'h0,        1, 10'd16, 32'h00001234, 32'h00001234, 32'h00001234, 0};

        for (int i = 0; i < 9; i++) begin
            a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_be = tbl[i].be;
            a_addr = tbl[i].aa; a_din = tbl[i].din;
            b_en = tbl[i].b_en; b_addr = tbl[i].ba;
            cycle();
            check($sformatf("vec%0d a_rvalid", i),  a_rvalid[0],  tbl[i].a_en);
            check($sformatf("vec%0d a_dout", i),    a_dout[0],    tbl[i].exp_a0);
            check($sformatf("vec%0d b_dout", i),    b_dout[0],    tbl[i].exp_b0);
            check($sformatf("vec%0d b_dout wf", i), b_dout[1],    tbl[i].exp_b1);
            check($sformatf("vec%0d collision", i), collision[0], tbl[i].exp_col);
            check($sformatf("vec%0d collision wf", i), collision[1], tbl[i].exp_col);
        end
        set_idle();

        // Output-register pipeline: back-to-back reads of 1, 2, 3.
        for (int i = 1; i <= 3; i++) begin
            a_en = 1; a_we = 1; a_be = 4'hF; a_addr = AW'(i); a_din = 32'h101 * i;
            cycle();
        end
        set_idle();
        cycle();
        cycle();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                a_en = 1; a_we = 0; a_addr = AW'(k + 1);
            end else begin
                set_idle();
            end
            cycle();
            check($sformatf("oreg step%0d a_rvalid", k), a_rvalid[2], oreg_v[k]);
            check($sformatf("oreg step%0d a_dout", k),   a_dout[2],   oreg_d[k]);
        end

        // Randomised traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            a_en   = 1'($urandom_range(0, 1));
            a_we   = 1'($urandom_range(0, 1));
            a_be   = 4'($urandom_range(0, 15));
            a_addr = AW'($urandom_range(0, 15));
            a_din  = $urandom;
            b_en   = 1'($urandom_range(0, 1));
            b_addr = AW'($urandom_range(0, 15));
            cycle();
        end

        // Reset with reads in flight: nothing may emerge afterwards.
        a_en = 1; a_we = 0; a_addr = 10'd3; b_en = 1; b_addr = 10'd4;
        cycle();
        assert_reset();
        set_idle();
        cycle();
        check("inflight a_rvalid oreg", a_rvalid[2], 0);
        check("inflight b_rvalid oreg", b_rvalid[2], 0);
        cycle();

        // Reset again 500 cycles into the sweep; the sweep must restart in full.
        reset = 1'b0;
        for (int i = 0; i < 500; i++) cycle();
        check("busy at sweep cycle 500", init_busy[0], 1);
        assert_reset();
        for (int i = 0; i < 3; i++) cycle();
        sweep_with_traffic("sweep length after mid-sweep reset");

        // Words written during the random phase must be cleared by the sweep.
        for (int i = 0; i < 16; i++) begin
            a_en = 1; a_we = 0; a_addr = AW'(i);
            cycle();
            check($sformatf("cleared addr %0d", i), a_dout[0], 32'h0);
        end
        set_idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised dual-port synchronous data RAM for the micro's data memory. Port A is read/write with per-byte write enables; port B is read-only (debug/second master). It adds a selectable read-during-write mode, an optional output pipeline register with read-valid flags, and a hardware clear sweep after reset. It replaces the single-port word RAM in the data path.

## Interface
- ANCHO, 32, data width in bits; multiple of 8, minimum 8.
- LARGO, 1024, depth in words; power of two, minimum 2.
- RDW_MODE, 0, same-address read during write: 0 = old data (read-first), 1 = new data (write-first).
- OUT_REG, 0, 1 = extra output register stage.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- init_busy  out  1  clear sweep in progress.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (qualified by a_en).
- a_be  in  ANCHO/8  port A byte enables; bit i covers bits [8i+7:8i].
- a_addr  in  $clog2(LARGO)  port A word address.
- a_din  in  ANCHO  port A write data.
- a_dout  out  ANCHO  port A read data.
- a_rvalid  out  1  a_dout valid this cycle.
- b_en  in  1  port B read request.
- b_addr  in  $clog2(LARGO)  port B word address.
- b_dout  out  ANCHO  port B read data.
- b_rvalid  out  1  b_dout valid this cycle.
- collision  out  1  B read the address A wrote in the same cycle; aligned with b_rvalid.

## Operation
- FSM states: INIT, RUN. reset asserted -> INIT, sweep counter = 0.
- INIT: one word cleared per cycle at counter address, counter +1; after address LARGO-1 cleared -> RUN. init_busy = 1 throughout INIT.
- During INIT all a_en/b_en ignored: no writes, rvalids stay 0.
- RUN, a_en & a_we: bytes with a_be[i] = 1 written from a_din; others retained. a_be = 0 is a no-op write.
- Every port A access (read or write) returns a word on a_dout: with a_we = 1, RDW_MODE 0 gives stored word before write, RDW_MODE 1 gives merged word after write.
- Port B read of the address port A writes in the same cycle: same RDW_MODE rule applied to B; collision = 1 with that b_rvalid. Otherwise collision = 0.
- No request on a port: its dout holds last value, rvalid = 0.
- Addresses are full-range; no wrap or error logic needed (LARGO is power of two).

## Timing
- Reset values: a_dout = 0, b_dout = 0, a_rvalid = 0, b_rvalid = 0, collision = 0, init_busy = 1.
- Clear sweep: exactly LARGO cycles; first RUN cycle is the edge after address LARGO-1 clears; init_busy falls on that edge.
- Read latency: 1 cycle (OUT_REG = 0) or 2 cycles (OUT_REG = 1) from request edge to rvalid = 1; fully pipelined, one request per port per cycle.
- Write committed at the request edge; a read on the next cycle sees it on either port.
- With OUT_REG = 1, requests in flight when reset asserts are dropped; no rvalid after reset.
- Reset mid-sweep: counter restarts at 0; full LARGO-cycle sweep repeated.

## Structure
- Package ram_pkg: RDW_OLD / RDW_NEW constants, byte-lane count function, FSM state enum (INIT, RUN).
- Sub-module ram_byte_merge: combinational merge of old word, a_din, a_be -> new word; used for write-first forwarding and the collision path.
- Storage as an inferred array with byte-lane write enables; no vendor primitives.

## Test plan
- Reset, 1024-deep default: init_busy high exactly 1024 cycles; a_en writes issued during sweep are dropped; then read addresses 0, 13, 1023 -> 0x00000000.
- Write addr 13 = 0x0000A234, a_be = 4'hF; read addr 13 next cycle -> a_dout = 0x0000A234, a_rvalid one cycle after request.
- Partial write: addr 16 holds 0x11223344; write 0xAABBCCDD with a_be = 4'b0101 -> read 0x11BB33DD.
- Same-cycle A write 0x00001234 / B read addr 16 (old 0x11BB33DD): RDW_MODE 0 -> b_dout 0x11BB33DD, RDW_MODE 1 -> 0x00001234; collision = 1 in both.
- OUT_REG = 1: back-to-back reads addrs 1, 2, 3 -> rvalid high 3 consecutive cycles starting 2 cycles after first request, data in order.
- Reset asserted at sweep cycle 500 -> init_busy stays high, sweep restarts, RUN reached 1024 cycles after reset release; all outputs at reset values meanwhile.
